slurm32_cpu_writeback: RTL and testbench
========================================

Name: slurm32_cpu_writeback

Overview:
Writeback stage directly upstream of the SLURM32 register file. It merges ALU results and in-order memory load returns onto the file's single write port (regIn_sel/regIn_data), which writes every clock. It keeps an in-order queue of destination registers for outstanding loads. It flags read-after-write hazards for the operand selects the decode stage is about to present to the file.

Parameters:
REG_BITS, 8, register index width (2**REG_BITS registers)
BITS, 32, data width
LDQ_DEPTH, 4, maximum outstanding loads (power of two, >=2)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
alu_valid  in  1  ALU result offered this cycle
alu_reg  in  REG_BITS  ALU destination register
alu_data  in  BITS  ALU result
alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
ld_issue  in  1  load issued to memory; push ld_reg
ld_reg  in  REG_BITS  load destination register
ld_issue_ready  out  1  load queue not full
ld_ret_valid  in  1  load data returns (strictly issue order, cannot be stalled)
ld_ret_data  in  BITS  returned load data
chk_a_sel  in  REG_BITS  operand A register about to be read
chk_b_sel  in  REG_BITS  operand B register about to be read
hazard_a  out  1  chk_a_sel has a write not yet committed to the file
hazard_b  out  1  same for chk_b_sel
ld_pending  out  1  load queue non-empty
ld_err  out  1  sticky: load return arrived with empty queue
regIn_sel  out  REG_BITS  register file write select
regIn_data  out  BITS  register file write data

Behaviour:
- Reset (RST high at posedge): regIn_sel=0, regIn_data=0, queue empty, skid empty, ld_err=0. While RST is high, alu_ready=0 and ld_issue_ready=0. hazard_a/b=0 after reset.
- Idle write: when nothing wins, regIn_sel=0 and regIn_data=0. The file always writes; r0 reads as zero, so this is harmless.
- Output register: one winner per cycle is registered into regIn_sel/regIn_data. The file commits at the following posedge, giving 2 edges of acceptance-to-commit latency.
- Priority: ld_ret > skid > direct ALU. Load returns are never delayed.
- Skid: one entry (reg, data, valid). When ld_ret_valid and ALU are accepted in the same cycle, the ALU result goes to the skid. alu_ready = !skid_valid (registered state; not combinational on ld_ret_valid).
  - No ld_ret and skid full: the skid drains.
  - No ld_ret and skid empty: an accepted ALU result goes straight to the output register.
- Load queue: FIFO of destination indices, LDQ_DEPTH entries, with wrapping read/write pointers and a count of width log2(LDQ_DEPTH)+1.
  - ld_issue_ready = (count != LDQ_DEPTH).
  - ld_issue while not ready is ignored.
  - Push and pop in the same cycle are allowed when the queue is neither full nor empty, or when it is full and an issue is blocked. The count is unchanged if both happen.
  - A return pops the head and writes head_reg with ld_ret_data.
- r0: a write targeting reg 0 from any source sets regIn_sel=0 and data=0. r0 loads are still queued and popped.
- Empty return: ld_ret_valid with an empty queue is dropped and sets ld_err. ld_err clears only on RST.
- Hazard (combinational from state): hazard_x=1 if chk_x_sel != 0 and it equals any of the following:
  - any valid queue entry
  - the valid skid reg
  - a non-zero regIn_sel in the output register
- Decode must stall while hazard_x=1 on sources and on the destination (WAW). This keeps ALU and load writes to one register ordered.
- ld_pending = (count != 0).
- Mid-operation reset discards queued loads, skid and output register contents. Memory must be reset concurrently.

Decomposition:
- Shared package slurm32_cpu_pkg: REG_BITS and BITS defaults, R0 index constant, typedef wb_entry_t {reg, data, valid}.
- One sub-module slurm32_ldq: dest-index FIFO with push/pop/full/empty/count and a per-entry match output for one compare index, instantiated logic duplicated per check port, or two compare inputs.
- Arbitration, skid and hazard OR logic stay in the top module.

Test Plan:
- Reset then idle 3 cycles -> regIn_sel=0, regIn_data=0, alu_ready=1, ld_issue_ready=1, hazards 0.
- ALU r5=0x12345678 accepted at cycle 0 -> regIn_sel=5, data=0x12345678 after the next posedge. hazard_a=1 for chk_a_sel=5 until the file commits; file read of r5 returns 0x12345678 thereafter.
- Issue loads r3, r4, then same-cycle ld_ret 0xAAAA0000 and ALU r7=0x77 -> r3 written first, r7 from skid next cycle, alu_ready=0 for exactly one cycle. hazard on r4 stays until its return.
- Issue 4 loads (LDQ_DEPTH=4) -> ld_issue_ready=0; a 5th ld_issue is ignored. After one return, ready=1 and count=3.
- ld_ret_valid with empty queue -> no write (regIn_sel=0), ld_err=1 and sticky until RST.
- ALU and load targeting r0 with data 0xFFFFFFFF -> regIn_sel=0, data=0. Load queue still pops; hazard on chk_sel=0 is never raised.

Source files
------------

// File: rtl/slurm32_cpu_pkg.sv
// Shared definitions for the SLURM32 writeback stage and its load queue.
package slurm32_cpu_pkg;

    localparam int DEF_REG_BITS  = 8;
    localparam int DEF_BITS      = 32;
    localparam int DEF_LDQ_DEPTH = 4;
    localparam int R0            = 0;

    typedef struct packed {
        logic [DEF_REG_BITS-1:0] regIdx;
        logic [DEF_BITS-1:0]     data;
        logic                    valid;
    } wb_entry_t;

endpackage

// File: rtl/slurm32_ldq.sv
// In-order FIFO of destination register indices for outstanding loads, with
// per-entry comparison against two operand selects.
module slurm32_ldq
    import slurm32_cpu_pkg::*;
#(
    parameter int REG_BITS = DEF_REG_BITS,
    parameter int DEPTH    = DEF_LDQ_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic [REG_BITS-1:0]      pushReg,
    input  logic                     pop,
    input  logic [REG_BITS-1:0]      cmpA,
    input  logic [REG_BITS-1:0]      cmpB,
    output logic [REG_BITS-1:0]      headReg,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     matchA,
    output logic                     matchB
);

    localparam int PTR_BITS = $clog2(DEPTH);

    logic [REG_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0] wrPtr;
    logic [PTR_BITS-1:0] rdPtr;
    logic [PTR_BITS-1:0] offset;
    logic                pushOk;
    logic                popOk;

    assign full    = (count == (PTR_BITS+1)'(DEPTH));
    assign empty   = (count == '0);
    assign headReg = mem[rdPtr];
    assign pushOk  = push && !full;
    assign popOk   = pop && !empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            // NOTE: entries are cleared too so a reset leaves no stale index that
            // could be mistaken for a live destination.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pushOk) begin
                mem[wrPtr] <= pushReg;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (popOk) rdPtr <= rdPtr + 1'b1;
            case ({pushOk, popOk})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        matchA = 1'b0;
        matchB = 1'b0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_BITS'(i) - rdPtr;
            if ((PTR_BITS+1)'(offset) < count) begin
                if (mem[i] == cmpA) matchA = 1'b1;
                if (mem[i] == cmpB) matchB = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slurm32_cpu_writeback.sv
// Writeback stage: merges ALU results and in-order load returns onto the
// register file write port and flags read-after-write hazards for decode.
module slurm32_cpu_writeback
    import slurm32_cpu_pkg::*;
#(
    parameter int REG_BITS  = DEF_REG_BITS,
    parameter int BITS      = DEF_BITS,
    parameter int LDQ_DEPTH = DEF_LDQ_DEPTH
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                alu_valid,
    input  logic [REG_BITS-1:0] alu_reg,
    input  logic [BITS-1:0]     alu_data,
    output logic                alu_ready,
    input  logic                ld_issue,
    input  logic [REG_BITS-1:0] ld_reg,
    output logic                ld_issue_ready,
    input  logic                ld_ret_valid,
    input  logic [BITS-1:0]     ld_ret_data,
    input  logic [REG_BITS-1:0] chk_a_sel,
    input  logic [REG_BITS-1:0] chk_b_sel,
    output logic                hazard_a,
    output logic                hazard_b,
    output logic                ld_pending,
    output logic                ld_err,
    output logic [REG_BITS-1:0] regIn_sel,
    output logic [BITS-1:0]     regIn_data
);

    localparam logic [REG_BITS-1:0] REG_ZERO = REG_BITS'(R0);

    logic                        skidValid;
    logic [REG_BITS-1:0]         skidReg;
    logic [BITS-1:0]             skidData;
    logic [REG_BITS-1:0]         headReg;
    logic                        ldqFull;
    logic                        ldqEmpty;
    logic [$clog2(LDQ_DEPTH):0]  ldqCount;
    logic                        ldqMatchA;
    logic                        ldqMatchB;
    logic                        aluAcc;
    logic                        ldPush;
    logic                        ldPop;
    logic [REG_BITS-1:0]         winSel;
    logic [BITS-1:0]             winData;
    logic                        skidLoad;
    logic                        skidClr;

    assign alu_ready      = !RST && !skidValid;
    assign ld_issue_ready = !RST && !ldqFull;
    assign ld_pending     = (ldqCount != '0);
    assign aluAcc         = alu_valid && alu_ready;
    assign ldPush         = ld_issue && ld_issue_ready;
    assign ldPop          = ld_ret_valid && !ldqEmpty;

    slurm32_ldq #(
        .REG_BITS (REG_BITS),
        .DEPTH    (LDQ_DEPTH)
    ) u_ldq (
        .CLK     (CLK),
        .RST     (RST),
        .push    (ldPush),
        .pushReg (ld_reg),
        .pop     (ldPop),
        .cmpA    (chk_a_sel),
        .cmpB    (chk_b_sel),
        .headReg (headReg),
        .full    (ldqFull),
        .empty   (ldqEmpty),
        .count   (ldqCount),
        .matchA  (ldqMatchA),
        .matchB  (ldqMatchB)
    );

    // Load returns cannot stall, so a colliding ALU result parks in the skid.
    always_comb begin
        winSel   = '0;
        winData  = '0;
        skidLoad = 1'b0;
        skidClr  = 1'b0;
        if (ldPop) begin
            winSel   = headReg;
            winData  = ld_ret_data;
            skidLoad = aluAcc;
        end else if (skidValid) begin
            winSel  = skidReg;
            winData = skidData;
            skidClr = 1'b1;
        end else if (aluAcc) begin
            winSel  = alu_reg;
            winData = alu_data;
        end
        if (winSel == REG_ZERO) winData = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            regIn_sel  <= '0;
            regIn_data <= '0;
            skidValid  <= 1'b0;
            skidReg    <= '0;
            skidData   <= '0;
            ld_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            regIn_sel  <= winSel;
            regIn_data <= winData;
            if (skidLoad) begin
                skidValid <= 1'b1;
                skidReg   <= alu_reg;
                skidData  <= alu_data;
            end else if (skidClr) begin
                skidValid <= 1'b0;
            end
            if (ld_ret_valid && ldqEmpty) ld_err <= 1'b1;
        end
    end

    assign hazard_a = (chk_a_sel != REG_ZERO) &&
                      (ldqMatchA || (skidValid && skidReg == chk_a_sel) || regIn_sel == chk_a_sel);
    assign hazard_b = (chk_b_sel != REG_ZERO) &&
                      (ldqMatchB || (skidValid && skidReg == chk_b_sel) || regIn_sel == chk_b_sel);

endmodule

// File: tb/tb_slurm32_cpu_writeback.sv
// Directed vector bench for slurm32_cpu_writeback with a register file model.
module tb_slurm32_cpu_writeback;

    logic        CLK = 1'b0;
    logic        RST;
    logic        alu_valid;
    logic [7:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    logic [7:0]  ld_reg;
    logic        ld_issue_ready;
    logic        ld_ret_valid;
    logic [31:0] ld_ret_data;
    logic [7:0]  chk_a_sel;
    logic [7:0]  chk_b_sel;
    logic        hazard_a;
    logic        hazard_b;
    logic        ld_pending;
    logic        ld_err;
    logic [7:0]  regIn_sel;
    logic [31:0] regIn_data;

    int nApplied = 0;
    int nMiss    = 0;

    logic [31:0] rf [256];

    always #5 CLK = ~CLK;

    slurm32_cpu_writeback dut (
        .CLK            (CLK),
        .RST            (RST),
        .alu_valid      (alu_valid),
        .alu_reg        (alu_reg),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .ld_issue       (ld_issue),
        .ld_reg         (ld_reg),
        .ld_issue_ready (ld_issue_ready),
        .ld_ret_valid   (ld_ret_valid),
        .ld_ret_data    (ld_ret_data),
        .chk_a_sel      (chk_a_sel),
        .chk_b_sel      (chk_b_sel),
        .hazard_a       (hazard_a),
        .hazard_b       (hazard_b),
        .ld_pending     (ld_pending),
        .ld_err         (ld_err),
        .regIn_sel      (regIn_sel),
        .regIn_data     (regIn_data)
    );

    // Register file model: writes every clock, as the real file does.
    always @(posedge CLK) rf[regIn_sel] <= regIn_data;

    typedef struct {
        logic        aluV;
        logic [7:0]  aluR;
        logic [31:0] aluD;
        logic        ldI;
        logic [7:0]  ldR;
        logic        ret;
        logic [31:0] retD;
        logic [7:0]  chkA;
        logic [7:0]  chkB;
        logic [7:0]  eSel;
        logic [31:0] eData;
        logic [5:0]  eFlags; // {alu_ready, ld_issue_ready, hazard_a, hazard_b, ld_pending, ld_err}
    } vec_t;

    vec_t vecs [31];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic aV, input logic [7:0] aR, input logic [31:0] aD,
                         input logic lI, input logic [7:0] lR, input logic rV, input logic [31:0] rD,
                         input logic [7:0] cA, input logic [7:0] cB);
        alu_valid = aV; alu_reg = aR; alu_data = aD;
        ld_issue = lI; ld_reg = lR; ld_ret_valid = rV; ld_ret_data = rD;
        chk_a_sel = cA; chk_b_sel = cB;
    endtask

    function automatic logic [5:0] flags();
        return {alu_ready, ld_issue_ready, hazard_a, hazard_b, ld_pending, ld_err};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) rf[i] = 32'h0;
        RST = 1'b1;
        drive(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 1'b0, 32'h0, 8'd0, 8'd0);

        vecs[0]  = '{1'b1, 8'd5,  32'h12345678, 1'b0, 8'd0,  1'b0, 32'h0,        8'd5,  8'd0,  8'd5,  32'h12345678, 6'b111000};
        vecs[1]  = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b0, 32'h0,        8'd5,  8'd0,  8'd0,  32'h0,        6'b110000};
        vecs[2]  = '{1'b0, 8'd0,  32'h0,        1'b1, 8'd3,  1'b0, 32'h0,        8'd3,  8'd4,  8'd0,  32'h0,        6'b111010};
        vecs[3]  = '{1'b0, 8'd0,  32'h0,        1'b1, 8'd4,  1'b0, 32'h0,        8'd3,  8'd4,  8'd0,  32'h0,        6'b111110};
        vecs[4]  = '{1'b1, 8'd7,  32'h77,       1'b0, 8'd0,  1'b1, 32'hAAAA0000, 8'd7,  8'd4,  8'd3,  32'hAAAA0000, 6'b011110};
        vecs[5]  = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b0, 32'h0,        8'd7,  8'd4,  8'd7,  32'h77,       6'b111110};
        vecs[6]  = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b0, 32'h0,        8'd7,  8'd3,  8'd0,  32'h0,        6'b110010};
        vecs[7]  = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b1, 32'h4444,     8'd4,  8'd0,  8'd4,  32'h4444,     6'b111000};
        vecs[8]  = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b0, 32'h0,        8'd4,  8'd0,  8'd0,  32'h0,        6'b110000};
        vecs[9]  = '{1'b0, 8'd0,  32'h0,        1'b1, 8'd10, 1'b0, 32'h0,        8'd13, 8'd10, 8'd0,  32'h0,        6'b110110};
        vecs[10] = '{1'b0, 8'd0,  32'h0,        1'b1, 8'd11, 1'b0, 32'h0,        8'd13, 8'd10, 8'd0,  32'h0,        6'b110110};
        vecs[11] = '{1'b0, 8'd0,  32'h0,        1'b1, 8'd12, 1'b0, 32'h0,        8'd13, 8'd10, 8'd0,  32'h0,        6'b110110};
        vecs[12] = '{1'b0, 8'd0,  32'h0,        1'b1, 8'd13, 1'b0, 32'h0,        8'd13, 8'd10, 8'd0,  32'h0,        6'b101110};
        vecs[13] = '{1'b0, 8'd0,  32'h0,        1'b1, 8'd14, 1'b0, 32'h0,        8'd14, 8'd10, 8'd0,  32'h0,        6'b100110};
        vecs[14] = '{1'b0, 8'd0,  32'h0,        1'b1, 8'd15, 1'b1, 32'h1010,     8'd15, 8'd10, 8'd10, 32'h1010,     6'b110110};
        vecs[15] = '{1'b0, 8'd0,  32'h0,        1'b1, 8'd20, 1'b1, 32'h1111,     8'd20, 8'd11, 8'd11, 32'h1111,     6'b111110};
        vecs[16] = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b1, 32'h1212,     8'd20, 8'd11, 8'd12, 32'h1212,     6'b111010};
        vecs[17] = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b1, 32'h1313,     8'd20, 8'd11, 8'd13, 32'h1313,     6'b111010};
        vecs[18] = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b1, 32'h2020,     8'd20, 8'd11, 8'd20, 32'h2020,     6'b111000};
        vecs[19] = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b0, 32'h0,        8'd20, 8'd11, 8'd0,  32'h0,        6'b110000};
        vecs[20] = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b1, 32'hDEAD,     8'd0,  8'd0,  8'd0,  32'h0,        6'b110001};
        vecs[21] = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b0, 32'h0,        8'd0,  8'd0,  8'd0,  32'h0,        6'b110001};
        vecs[22] = '{1'b1, 8'd0,  32'hFFFFFFFF, 1'b0, 8'd0,  1'b0, 32'h0,        8'd0,  8'd0,  8'd0,  32'h0,        6'b110001};
        vecs[23] = '{1'b0, 8'd0,  32'h0,        1'b1, 8'd0,  1'b0, 32'h0,        8'd0,  8'd0,  8'd0,  32'h0,        6'b110011};
        vecs[24] = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b1, 32'hFFFFFFFF, 8'd0,  8'd0,  8'd0,  32'h0,        6'b110001};
        vecs[25] = '{1'b0, 8'd0,  32'h0,        1'b1, 8'd1,  1'b0, 32'h0,        8'd1,  8'd6,  8'd0,  32'h0,        6'b111011};
        vecs[26] = '{1'b0, 8'd0,  32'h0,        1'b1, 8'd2,  1'b0, 32'h0,        8'd1,  8'd6,  8'd0,  32'h0,        6'b111011};
        vecs[27] = '{1'b1, 8'd6,  32'h66,       1'b0, 8'd0,  1'b1, 32'h11,       8'd1,  8'd6,  8'd1,  32'h11,       6'b011111};
        vecs[28] = '{1'b1, 8'd9,  32'h99,       1'b0, 8'd0,  1'b1, 32'h22,       8'd1,  8'd6,  8'd2,  32'h22,       6'b010101};
        vecs[29] = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b0, 32'h0,        8'd1,  8'd6,  8'd6,  32'h66,       6'b110101};
        vecs[30] = '{1'b0, 8'd0,  32'h0,        1'b0, 8'd0,  1'b0, 32'h0,        8'd1,  8'd6,  8'd0,  32'h0,        6'b110001};

        // Reset: ready outputs held low while RST is high.
        tick();
        tick();
        check("rst alu_ready", {31'h0, alu_ready}, 32'h0);
        check("rst ld_issue_ready", {31'h0, ld_issue_ready}, 32'h0);
        check("rst regIn_sel", {24'h0, regIn_sel}, 32'h0);
        RST = 1'b0;
        tick(); tick(); tick();
        check("idle regIn_sel", {24'h0, regIn_sel}, 32'h0);
        check("idle regIn_data", regIn_data, 32'h0);
        check("idle flags", {26'h0, flags()}, {26'h0, 6'b110000});

        for (int i = 0; i < 31; i++) begin
            drive(vecs[i].aluV, vecs[i].aluR, vecs[i].aluD, vecs[i].ldI, vecs[i].ldR,
                  vecs[i].ret, vecs[i].retD, vecs[i].chkA, vecs[i].chkB);
            tick();
            check($sformatf("vec%0d regIn_sel", i), {24'h0, regIn_sel}, {24'h0, vecs[i].eSel});
            check($sformatf("vec%0d regIn_data", i), regIn_data, vecs[i].eData);
            check($sformatf("vec%0d flags", i), {26'h0, flags()}, {26'h0, vecs[i].eFlags});
        end

        check("rf r5", rf[5], 32'h12345678);
        check("rf r3", rf[3], 32'hAAAA0000);
        check("rf r7", rf[7], 32'h77);
        check("rf r4", rf[4], 32'h4444);
        check("rf r6", rf[6], 32'h66);
        check("rf r9 untouched", rf[9], 32'h0);
        check("rf r0", rf[0], 32'h0);

        // Mid-operation reset with a load outstanding and the skid occupied.
        drive(1'b0, 8'd0, 32'h0, 1'b1, 8'd9, 1'b0, 32'h0, 8'd8, 8'd9);
        tick();
        drive(1'b0, 8'd0, 32'h0, 1'b1, 8'd10, 1'b0, 32'h0, 8'd8, 8'd10);
        tick();
        drive(1'b1, 8'd8, 32'h88, 1'b0, 8'd0, 1'b1, 32'h99, 8'd8, 8'd10);
        tick();
        check("pre-rst regIn_sel", {24'h0, regIn_sel}, 32'd9);
        check("pre-rst flags", {26'h0, flags()}, {26'h0, 6'b011111});
        drive(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 1'b0, 32'h0, 8'd8, 8'd10);
        RST = 1'b1;
        tick();
        check("mid-rst regIn_sel", {24'h0, regIn_sel}, 32'h0);
        check("mid-rst flags", {26'h0, flags()}, {26'h0, 6'b000000});
        RST = 1'b0;
        tick();
        check("post-rst regIn_sel", {24'h0, regIn_sel}, 32'h0);
        check("post-rst regIn_data", regIn_data, 32'h0);
        check("post-rst flags", {26'h0, flags()}, {26'h0, 6'b110000});

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule
